// File: rtl/img_pkg.sv
// Shared image-path constants and the frame sink state encoding.
package img_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int PIX_W     = 8;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int ADDR_W    = $clog2(FRAME_PIX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2
  } state_e;

endpackage

// File: rtl/enhanced_frame_sink_if.sv
// Pixel-in / replay-out signal bundle for the frame sink.
interface enhanced_frame_sink_if #(
  parameter int PIX_W = img_pkg::PIX_W
);
  // Input side has no backpressure: pix_in is taken whenever pix_valid is high.
  // Output side: a pixel transfers on a cycle with out_valid & out_ready; while
  // out_valid is high and out_ready low, out_pix and out_valid do not change.
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic [PIX_W-1:0] out_pix;
  logic             out_valid;
  logic             out_ready;
  logic             frame_done;
  logic             busy;
  logic             overflow;

  modport master (
    output pix_in, pix_valid, out_ready,
    input  out_pix, out_valid, frame_done, busy, overflow
  );

  modport slave (
    input  pix_in, pix_valid, out_ready,
    output out_pix, out_valid, frame_done, busy, overflow
  );
endinterface

// File: rtl/frame_buffer_ram.sv
// Single-port frame store with a registered (1-cycle) read port.
module frame_buffer_ram #(
  parameter int DEPTH  = img_pkg::FRAME_PIX,
  parameter int DATA_W = img_pkg::PIX_W,
  parameter int ADDR_W = img_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/enhanced_frame_sink.sv
// Captures one raster frame into the frame buffer, then replays it over a
// ready/valid port. Capture and replay never overlap, so one RAM port is shared.
module enhanced_frame_sink #(
  parameter int IMG_W = img_pkg::IMG_W,
  parameter int IMG_H = img_pkg::IMG_H,
  parameter int PIX_W = img_pkg::PIX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  enhanced_frame_sink_if.slave   bus,
  output img_pkg::state_e        state_dbg
);
  import img_pkg::*;

  localparam int FRAME_N = IMG_W * IMG_H;
  localparam int AW      = $clog2(FRAME_N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_N - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [PIX_W-1:0]  ram_q;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic              hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // rd_addr_q is the address of the pixel on out_pix; the RAM is addressed one
  // ahead only on a handshake, so a stalled pixel is simply re-read unchanged.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    ram_we       = 1'b0;
    ram_addr     = wr_addr_q;
    hs           = out_valid_q & bus.out_ready;
    unique case (state_q)
      IDLE, CAPTURE: begin
        if (bus.pix_valid) begin
          ram_we  = 1'b1;
          state_d = CAPTURE;
          if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d    = '0;
            state_d      = READOUT;
            frame_done_d = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      READOUT: begin
        out_valid_d = 1'b1;
        ram_addr    = hs ? rd_addr_q + 1'b1 : rd_addr_q;
        if (bus.pix_valid) overflow_d = 1'b1;
        if (hs) begin
          if (rd_addr_q == LAST_ADDR) begin
            rd_addr_d   = '0;
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  frame_buffer_ram #(
    .DEPTH  (FRAME_N),
    .DATA_W (PIX_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.pix_in),
    .rdata (ram_q)
  );

  // RAM output is undefined after reset, so out_pix is forced to 0 when idle.
  assign bus.out_pix    = out_valid_q ? ram_q : '0;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overflow   = overflow_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_enhanced_frame_sink.sv
// Directed bench for enhanced_frame_sink on a reduced 32x8 frame (256 pixels).
module tb_enhanced_frame_sink;

  localparam int W     = 32;
  localparam int H     = 8;
  localparam int PW    = 8;
  localparam int FRAME = W * H;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  img_pkg::state_e state_dbg;
  int              total = 0;
  int              bad = 0;
  int              fd_count = 0;
  int              fd_clash = 0;
  int              fd_base;
  int              cycles;
  logic [PW-1:0]   exp_q[$];

  enhanced_frame_sink_if #(.PIX_W(PW)) bus ();

  enhanced_frame_sink #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_done) fd_count++;
      if (bus.frame_done && bus.out_valid) fd_clash++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: kind 0 = ramp (addr%256), 1 = random, 2 = constant 0x5A
  task automatic send_pixels(input int kind, input int gap_pct, input int n);
    for (int i = 0; i < n; i++) begin
      logic [PW-1:0] v;
      while ($urandom_range(99) < gap_pct) begin
        bus.pix_valid = 1'b0;
        cyc();
      end
      case (kind)
        0:       v = PW'(i);
        1:       v = PW'($urandom_range(255));
        default: v = 8'h5A;
      endcase
      bus.pix_valid = 1'b1;
      bus.pix_in    = v;
      exp_q.push_back(v);
      cyc();
    end
    bus.pix_valid = 1'b0;
  endtask

  // called in cycle T+1 after the last write
  task automatic check_handoff();
    check("fd_pulse", bus.frame_done, 1);
    check("fd_no_valid", bus.out_valid, 0);
    check("fd_busy", bus.busy, 1);
    cyc();
    check("fd_clear", bus.frame_done, 0);
    check("first_valid", bus.out_valid, 1);
    check("first_pix", bus.out_pix, exp_q[0]);
  endtask

  // scoreboard-driven consumer
  task automatic drain(input int stall_pct, input int nexp, input int abort_at,
                       input bit inj_mid, input bit inj_last, output int ncyc);
    int            got = 0;
    bit            held_v = 1'b0;
    logic [PW-1:0] held_p = '0;
    ncyc = 0;
    while (got < nexp && ncyc < 20 * FRAME) begin
      if (got == abort_at) break;
      if (held_v) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_pix", bus.out_pix, held_p);
      end
      bus.out_ready = ($urandom_range(99) >= stall_pct);
      bus.pix_valid = 1'b0;
      if (inj_mid && got >= 10 && got < 13) begin
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'hAA;
      end
      if (inj_last && got == nexp - 1 && bus.out_valid && bus.out_ready) begin
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'hAA;
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("out_unexpected", bus.out_valid, 0);
        else check("out_pix", bus.out_pix, exp_q[0]);
        if (bus.out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_p = bus.out_pix;
      cyc();
      ncyc++;
    end
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b0;
    if (abort_at < 0) begin
      check("drain_count", got, nexp);
      check("end_valid", bus.out_valid, 0);
      check("end_busy", bus.busy, 0);
    end
  endtask

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pix", bus.out_pix, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_state", 32'(state_dbg), 32'(img_pkg::IDLE));
    rst = 1'b0;
    cyc();

    // 1: ramp, continuous, full throughput
    send_pixels(0, 0, FRAME);
    check_handoff();
    drain(0, FRAME, -1, 1'b0, 1'b0, cycles);
    check("t1_throughput", cycles, FRAME);
    check("t1_overflow", bus.overflow, 0);

    // 2: random gaps and random stalls
    send_pixels(1, 50, FRAME);
    check_handoff();
    drain(30, FRAME, -1, 1'b0, 1'b0, cycles);

    // 6: frame B begins the cycle after A's last handshake
    send_pixels(0, 0, FRAME);
    check_handoff();
    drain(0, FRAME, -1, 1'b0, 1'b0, cycles);
    send_pixels(1, 0, FRAME);
    check_handoff();
    drain(20, FRAME, -1, 1'b0, 1'b0, cycles);
    check("t6_overflow", bus.overflow, 0);

    // 3: pixels during readout, including the final-handshake cycle
    send_pixels(1, 0, FRAME);
    check_handoff();
    drain(0, FRAME, -1, 1'b1, 1'b1, cycles);
    check("t3_overflow", bus.overflow, 1);
    send_pixels(0, 0, FRAME);
    check_handoff();
    drain(10, FRAME, -1, 1'b0, 1'b0, cycles);
    check("t3_overflow_sticky", bus.overflow, 1);

    // 4: reset mid-capture, then a clean 0x5A frame
    send_pixels(1, 0, 100);
    rst = 1'b1;
    cyc();
    check("t4_rst_busy", bus.busy, 0);
    rst = 1'b0;
    exp_q.delete();
    cyc();
    check("t4_overflow_cleared", bus.overflow, 0);
    fd_base = fd_count;
    send_pixels(2, 0, FRAME);
    check_handoff();
    drain(0, FRAME, -1, 1'b0, 1'b0, cycles);
    check("t4_fd_once", fd_count - fd_base, 1);
    check("t4_overflow", bus.overflow, 0);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: reset during readout at pixel 100, then a clean frame
    send_pixels(0, 0, FRAME);
    check_handoff();
    drain(0, FRAME, 100, 1'b0, 1'b0, cycles);
    check("t5_valid_before", bus.out_valid, 1);
    rst = 1'b1;
    cyc();
    check("t5_valid", bus.out_valid, 0);
    check("t5_pix", bus.out_pix, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_state", 32'(state_dbg), 32'(img_pkg::IDLE));
    rst = 1'b0;
    exp_q.delete();
    cyc();
    send_pixels(1, 0, FRAME);
    check_handoff();
    drain(0, FRAME, -1, 1'b0, 1'b0, cycles);

    check("fd_vs_valid", fd_clash, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
